// File: rtl/converted_number_buffer_pkg.sv
// Shared widths, depth and drain FSM encoding for the converted-number buffer.
package converted_number_buffer_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  // Highest index; the entry counter saturates here.
  localparam logic [ADDR_W-1:0] NUM_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/number_ram.sv
// 32 x 16 storage: synchronous write, asynchronous read, contents never reset.
module number_ram
  import converted_number_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/converted_number_buffer.sv
// Collects converted numbers while idle, then drains entries 0..num-1 over a
// valid/ready stream when writeToFile pulses.
module converted_number_buffer
  import converted_number_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] convNum,
  input  logic              storeConvertedNumber,
  input  logic              enC,
  input  logic              writeToFile,
  output logic [ADDR_W-1:0] num,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              done,
  output logic              overflow
);

  state_e            state_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              done_q;
  logic              overflow_q;
  logic              full_q;

  logic              store_drop;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // A store at the last index is accepted once; later ones are dropped.
  assign store_drop = (num_q == NUM_MAX) && full_q;
  assign wr_en      = (state_q == IDLE) && storeConvertedNumber && !store_drop
                      && !rst && !clear;
  assign rd_addr    = (state_q == LOAD) ? '0 : rd_ptr_q + ADDR_W'(1);

  number_ram u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (num_q),
    .wdata_i (convNum),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            num_q      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
          end else begin
            if (writeToFile) begin
              state_q <= LOAD;
            end
            if (storeConvertedNumber) begin
              if (store_drop) begin
                overflow_q <= 1'b1;
              end else if (num_q == NUM_MAX) begin
                full_q <= 1'b1;
              end
            end
            if (enC && (num_q != NUM_MAX)) begin
              num_q <= num_q + ADDR_W'(1);
            end
          end
        end
        LOAD: begin
          rd_ptr_q <= '0;
          if (num_q == '0) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            out_data_q  <= rd_data;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid_q && outReady) begin
            if (rd_ptr_q == num_q - ADDR_W'(1)) begin
              out_valid_q <= 1'b0;
              state_q     <= FINISH;
              done_q      <= 1'b1;
            end else begin
              // rd_addr already points at rd_ptr_q + 1, so no bubble.
              rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
              out_data_q <= rd_data;
            end
          end
        end
        FINISH: begin
          num_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign num      = num_q;
  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_converted_number_buffer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops them.
module tb_converted_number_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [15:0] convNum;
  logic        storeConvertedNumber;
  logic        enC;
  logic        writeToFile;
  logic [4:0]  num;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  logic [15:0] exp_q [$];

  converted_number_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .convNum              (convNum),
    .storeConvertedNumber (storeConvertedNumber),
    .enC                  (enC),
    .writeToFile          (writeToFile),
    .num                  (num),
    .outData              (outData),
    .outValid             (outValid),
    .outReady             (outReady),
    .done                 (done),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store_inc(input logic [15:0] val);
    convNum = val;
    storeConvertedNumber = 1'b1;
    enC = 1'b1;
    tick();
    storeConvertedNumber = 1'b0;
    enC = 1'b0;
  endtask

  task automatic store_only(input logic [15:0] val);
    convNum = val;
    storeConvertedNumber = 1'b1;
    tick();
    storeConvertedNumber = 1'b0;
  endtask

  task automatic pulse_wtf();
    writeToFile = 1'b1;
    tick();
    writeToFile = 1'b0;
  endtask

  // Monitor: pops on every handshake and checks hold during stalls.
  initial begin
    logic        stall_prev;
    logic [15:0] data_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst && stall_prev) begin
        chk("hold_data", outData, data_prev);
        chk("hold_valid", outValid, 1);
      end
      if (outValid && outReady) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%0h required=none", outData);
        end else begin
          chk("beat_data", outData, exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
      stall_prev = outValid && !outReady && !rst;
      data_prev  = outData;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int d0;
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; clear = 1'b0; convNum = '0; storeConvertedNumber = 1'b0;
    enC = 1'b0; writeToFile = 1'b0; outReady = 1'b0;
    repeat (3) tick();
    chk("rst_num", num, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", outData, 16'h0000);
    rst = 1'b0;

    // 26-entry full-rate drain
    for (int i = 0; i < 26; i++) begin
      store_inc(16'h0100 + 16'(i));
      exp_q.push_back(16'h0100 + 16'(i));
    end
    chk("num_26", num, 26);
    outReady = 1'b1;
    pulse_wtf();
    chk("valid_after_1", outValid, 0);
    tick();
    chk("first_beat_latency", outValid, 1);
    for (int k = 2; k <= 26; k++) begin
      tick();
      chk("beat_consecutive", outValid, 1);
    end
    tick();
    chk("drain26_valid_drop", outValid, 0);
    chk("drain26_done", done, 1);
    tick();
    chk("drain26_done_once", done, 0);
    chk("drain26_num0", num, 0);

    // 3-entry drain with backpressure
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store_inc(16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
    end
    pulse_wtf();
    tick();
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      outReady = pat[i];
      tick();
    end
    outReady = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_handshakes", hs_cnt - hs0, 3);
    tick();
    chk("bp_num0", num, 0);

    // empty drain
    pulse_wtf();
    chk("empty_done_early", done, 0);
    tick();
    chk("empty_done", done, 1);
    chk("empty_valid", outValid, 0);
    tick();
    chk("empty_done_once", done, 0);

    // simultaneous store+enC, inputs ignored during drain
    for (int i = 0; i < 4; i++) store_inc(16'h5000 + 16'(i));
    store_inc(16'hABCD);
    chk("num_5", num, 5);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h5000 + 16'(i));
    exp_q.push_back(16'hABCD);
    outReady = 1'b1;
    hs0 = hs_cnt;
    d0 = done_cnt;
    pulse_wtf();
    tick();
    writeToFile = 1'b1; enC = 1'b1; clear = 1'b1;
    storeConvertedNumber = 1'b1; convNum = 16'hFFFF;
    tick();
    writeToFile = 1'b0; enC = 1'b0; clear = 1'b0; storeConvertedNumber = 1'b0;
    chk("drain_num_held", num, 5);
    repeat (3) tick();
    tick();
    chk("drain5_done", done, 1);
    tick();
    chk("drain5_num0", num, 0);
    repeat (4) begin
      tick();
      chk("no_second_drain", outValid, 0);
    end
    chk("drain5_handshakes", hs_cnt - hs0, 5);
    chk("drain5_done_count", done_cnt - d0, 1);

    // reset mid-drain
    for (int i = 0; i < 5; i++) store_inc(16'h6000 + 16'(i));
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'h6001);
    d0 = done_cnt;
    pulse_wtf();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", outValid, 0);
    chk("abort_num", num, 0);
    chk("abort_done", done, 0);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    // storage survives reset
    enC = 1'b1;
    tick();
    tick();
    enC = 1'b0;
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'h6001);
    pulse_wtf();
    repeat (5) tick();
    chk("retained_queue_empty", exp_q.size(), 0);
    chk("retained_num0", num, 0);

    // saturation and overflow
    enC = 1'b1;
    repeat (32) tick();
    enC = 1'b0;
    chk("num_saturate", num, 31);
    store_only(16'h7777);
    chk("ovf_first_store", overflow, 0);
    store_only(16'h8888);
    chk("ovf_set", overflow, 1);
    chk("ovf_num", num, 31);
    tick();
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", overflow, 0);
    chk("clear_num", num, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/converted_number_buffer.md
CONVERTED_NUMBER_BUFFER -- requirements
Module: converted_number_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 clear  input  1  synchronous clear of count, write pointer and overflow; same effect as rst except drain output is unaffected mid-transfer.
REQ-005 convNum  input  16  converted number from the conversion datapath.
REQ-006 storeConvertedNumber  input  1  write convNum at index num.
REQ-007 enC  input  1  increment num.
REQ-008 writeToFile  input  1  single-cycle pulse that starts the drain.
REQ-009 num  output  5  count of stored entries, fed back to the controller for its num > 25 test.
REQ-010 outData  output  16  drained entry.
REQ-011 outValid  output  1  outData is valid.
REQ-012 outReady  input  1  downstream file-writer accepts outData.
REQ-013 done  output  1  one-cycle pulse when the drain completes.
REQ-014 overflow  output  1  sticky flag: a store was attempted while full.

Function
REQ-015 Storage SHALL be 32 entries x 16 bits, indexed 0..31.
REQ-016 In IDLE, storeConvertedNumber SHALL write convNum to entry num on the same edge; num is unchanged by the store itself.
REQ-017 enC SHALL increment num by 1, saturating at 31; when num = 31, enC has no effect.
REQ-018 Store and enC in the same cycle SHALL write at the old num, then increment.
REQ-019 A store when num = 31 and entry 31 was already written since clear SHALL be dropped, and overflow SHALL be set and held until rst or clear.
REQ-020 FSM states SHALL be IDLE, LOAD, DRAIN and FINISH.
REQ-021 IDLE -> LOAD on writeToFile; writeToFile in any other state SHALL be ignored.
REQ-022 LOAD: the read pointer is set to 0; if num = 0, go to FINISH; otherwise register entry 0 on outData, assert outValid, and go to DRAIN.
REQ-023 outValid SHALL therefore rise exactly 2 cycles after the writeToFile pulse.
REQ-024 In DRAIN, while outValid && !outReady, outData and outValid SHALL hold stable.
REQ-025 On outValid && outReady, the read pointer SHALL advance and the next entry SHALL be presented on the following cycle, with no bubble.
REQ-026 When the entry at index num-1 is accepted, outValid SHALL drop and the FSM SHALL go to FINISH.
REQ-027 FINISH SHALL pulse done for one cycle, zero num, and return to IDLE.
REQ-028 storeConvertedNumber and enC SHALL be ignored outside IDLE.
REQ-029 clear received during DRAIN SHALL be ignored until IDLE.
REQ-030 Exactly num entries SHALL be emitted per drain, in index order 0..num-1.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE, and num, the read pointer, outValid, done and overflow SHALL all be 0; outData SHALL be 16'h0000.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 rst asserted mid-drain SHALL abort the drain on the same edge, with no done pulse.

Structure
REQ-034 A shared package SHALL hold DATA_W = 16, DEPTH = 32, ADDR_W = 5 and the state encoding (IDLE = 0, LOAD = 1, DRAIN = 2, FINISH = 3).
REQ-035 Storage SHALL be a separate sub-module number_ram, with synchronous write, asynchronous read and no reset.
REQ-036 FSM, counter and output register SHALL reside in converted_number_buffer.

Verification
REQ-037 Store 26 values 0x0100..0x0119, each with enC -> num = 26; writeToFile with outReady = 1 -> 26 beats 0x0100..0x0119 on consecutive cycles, first beat 2 cycles after the pulse, done one cycle after the last beat, then num = 0.
REQ-038 Drain 3 entries with outReady toggled 1,0,0,1,1 -> outData holds during the low cycles; exactly 3 handshakes; order preserved.
REQ-039 num = 0, writeToFile -> no outValid; done 2 cycles after the pulse.
REQ-040 Store at num = 31 twice -> num stays 31; overflow = 1; clear -> overflow = 0 and num = 0.
REQ-041 rst asserted on the 2nd beat of a 5-entry drain -> outValid = 0 next cycle, no done, num = 0.
REQ-042 Simultaneous store 0xABCD and enC at num = 4 -> entry 4 = 0xABCD and num = 5; writeToFile during DRAIN -> ignored, drain length unchanged.
